// File: rtl/wb_regfile.sv
// wb_regfile: write-back end of the MEM/WB interface plus the 32-entry GPR file.
//   clk, reset        : rising-edge clock, synchronous active-high reset
//   regWrite          : write-back enable from MEM/WB
//   memtoreg          : 1 selects read_data (load), 0 selects data_addr (ALU result)
//   writeReg          : destination register index
//   read_data         : memory load data
//   data_addr         : ALU result / data address
//   readReg1/2        : decode-stage source indices (rs, rt)
//   readData1/2       : combinational read results, with same-cycle write bypass
//   wbData            : selected write-back value (to forwarding unit)
//   wbValid           : write-back commits on this edge
//   writeCount        : number of committed writes, wraps at 2**32

// One combinational read port. The bypass term lets decode see the value
// committing on this edge, so no negedge write is needed.
module wb_rd_port #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREGS  = 32
) (
  input  logic                          reset,
  input  logic [ADDR_W-1:0]             raddr,
  input  logic                          wb_valid,
  input  logic [ADDR_W-1:0]             waddr,
  input  logic [DATA_W-1:0]             wb_data,
  input  logic [NREGS-1:0][DATA_W-1:0]  regs,
  output logic [DATA_W-1:0]             rdata
);
  always_comb begin
    rdata = regs[raddr];
    if (reset)                           rdata = '0;
    else if (raddr == '0)                rdata = '0;
    else if (wb_valid && waddr == raddr) rdata = wb_data;
  end
endmodule

module wb_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREGS  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              regWrite,
  input  logic              memtoreg,
  input  logic [ADDR_W-1:0] writeReg,
  input  logic [DATA_W-1:0] read_data,
  input  logic [DATA_W-1:0] data_addr,
  input  logic [ADDR_W-1:0] readReg1,
  input  logic [ADDR_W-1:0] readReg2,
  output logic [DATA_W-1:0] readData1,
  output logic [DATA_W-1:0] readData2,
  output logic [DATA_W-1:0] wbData,
  output logic              wbValid,
  output logic [31:0]       writeCount
);
  localparam int NUM_RD = 2;

  logic [NREGS-1:0][DATA_W-1:0]  regs;
  logic [31:0]                   write_cnt;
  logic [NUM_RD-1:0][ADDR_W-1:0] rd_addr;
  logic [NUM_RD-1:0][DATA_W-1:0] rd_data;

  assign wbData     = memtoreg ? read_data : data_addr;
  // Index 0 is excluded here, so r0 is never written and never counted.
  assign wbValid    = regWrite & (writeReg != '0) & ~reset;
  assign writeCount = write_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      regs      <= '0;
      write_cnt <= '0;
    end else if (wbValid) begin
      regs[writeReg] <= wbData;
      write_cnt      <= write_cnt + 32'd1;
    end
  end

  assign rd_addr[0] = readReg1;
  assign rd_addr[1] = readReg2;
  assign readData1  = rd_data[0];
  assign readData2  = rd_data[1];

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    wb_rd_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREGS(NREGS)) u_rd (
      .reset    (reset),
      .raddr    (rd_addr[p]),
      .wb_valid (wbValid),
      .waddr    (writeReg),
      .wb_data  (wbData),
      .regs     (regs),
      .rdata    (rd_data[p])
    );
  end
endmodule
